// File: rtl/cdb_arbiter_n.sv
// Common data bus arbiter: per-source holding FIFOs feed NUM_CH registered
// broadcast channels, granted in fixed-priority or round-robin order.

module cdb_fifo #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              enq,
  input  logic [DATA_W-1:0] wdata,
  input  logic [TAG_W-1:0]  wtag,
  input  logic              deq,
  output logic [DATA_W-1:0] head_data,
  output logic [TAG_W-1:0]  head_tag,
  output logic              not_empty,
  output logic              ready
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  logic [DATA_W+TAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [PW:0]             cnt;

  assign {head_tag, head_data} = mem[rd_ptr];
  assign not_empty = (cnt != '0);
  assign ready     = (cnt != FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      // enqueue and dequeue together leave occupancy unchanged
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= {wtag, wdata};
  end
endmodule

module cdb_arbiter_n #(
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 5,
  parameter int NUM_SRC  = 3,
  parameter int NUM_CH   = 2,
  parameter int DEPTH    = 2,
  parameter int ARB_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [NUM_CH-1:0]         cdb_valid,
  output logic [NUM_CH*DATA_W-1:0]  cdb_data,
  output logic [NUM_CH*TAG_W-1:0]   cdb_tag,
  output logic [NUM_CH*3-1:0]       cdb_src,
  output logic                      overflow_err
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_SRC-1:0][DATA_W-1:0] sdata, head_data;
  logic [NUM_SRC-1:0][TAG_W-1:0]  stag, head_tag;
  logic [NUM_SRC-1:0]             enq, grant, not_empty;

  logic [NUM_CH-1:0]              ch_vld;
  logic [NUM_CH-1:0][SW-1:0]      ch_src;
  logic [NUM_CH-1:0][DATA_W-1:0]  ch_data, data_q;
  logic [NUM_CH-1:0][TAG_W-1:0]   ch_tag, tag_q;
  logic [NUM_CH-1:0][2:0]         ch_src3, src_q;
  logic [SW-1:0]                  rr_ptr, nxt_rr;

  assign sdata    = src_data;
  assign stag     = src_tag;
  assign cdb_data = data_q;
  assign cdb_tag  = tag_q;
  assign cdb_src  = src_q;
  // a flush cycle never enqueues, whatever src_valid says
  assign enq      = src_valid & src_ready & {NUM_SRC{~flush}};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .enq       (enq[i]),
      .wdata     (sdata[i]),
      .wtag      (stag[i]),
      .deq       (grant[i]),
      .head_data (head_data[i]),
      .head_tag  (head_tag[i]),
      .not_empty (not_empty[i]),
      .ready     (src_ready[i])
    );
  end

  // Walk sources from the start point, packing winners densely into channels.
  always_comb begin
    int idx;
    int n;
    int start;
    logic [SW-1:0] sel;
    grant  = '0;
    ch_vld = '0;
    ch_src = '0;
    nxt_rr = rr_ptr;
    n      = 0;
    sel    = '0;
    start  = (ARB_MODE == 1) ? int'(rr_ptr) : 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = start + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      sel = SW'(idx);
      if (not_empty[sel] && n < NUM_CH) begin
        grant[sel]        = 1'b1;
        ch_vld[CW'(n)]    = 1'b1;
        ch_src[CW'(n)]    = sel;
        nxt_rr            = (idx + 1 == NUM_SRC) ? '0 : SW'(idx + 1);
        n                 = n + 1;
      end
    end
  end

  always_comb begin
    ch_data = '0;
    ch_tag  = '0;
    ch_src3 = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_vld[c]) begin
        ch_data[c] = head_data[ch_src[c]];
        ch_tag[c]  = head_tag[ch_src[c]];
        ch_src3[c] = 3'(ch_src[c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      src_q     <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= '0;
      data_q    <= '0;
      tag_q     <= '0;
      src_q     <= '0;
      rr_ptr    <= '0;
    end else begin
      cdb_valid <= ch_vld;
      data_q    <= ch_data;
      tag_q     <= ch_tag;
      src_q     <= ch_src3;
      rr_ptr    <= nxt_rr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           overflow_err <= 1'b0;
    else if (|(src_valid & ~src_ready))   overflow_err <= 1'b1;
  end
endmodule
